// File: rtl/encoder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : encoder_pkg
// Description : Shared types, constants and helpers for prio_encoder_drain.
//               Optional build macro used by this block:
//               PRIO_ENCODER_MSB_FIRST_EN (bit N-1 wins, descending drain).
// Revision    : 1.0 - initial release
// ============================================================================
package encoder_pkg;

  // Default number of request lines.
  localparam int DEFAULT_N = 8;

  // Two-state handshake controller: waiting for a vector, or emitting beats.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  // Index width for an n-line encoder; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/prio_find.sv
`default_nettype none
// ============================================================================
// Module      : prio_find
// Description : Combinational priority finder. Returns the index of the
//               lowest set bit (highest set bit when PRIO_ENCODER_MSB_FIRST_EN
//               is defined) and flags vectors with exactly one bit set.
//               An all-zero vector yields index 0.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_find
  import encoder_pkg::*;
#(
  parameter  int N = DEFAULT_N,
  localparam int W = idx_width(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         single_o
);

  logic w_found;

  // Scan from the highest-priority end; the first set bit wins.
  always_comb begin
    idx_o   = '0;
    w_found = 1'b0;
`ifdef PRIO_ENCODER_MSB_FIRST_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (!w_found && vec_i[k]) begin
        idx_o   = W'(k);
        w_found = 1'b1;
      end
    end
`else
    for (int k = 0; k < N; k++) begin
      if (!w_found && vec_i[k]) begin
        idx_o   = W'(k);
        w_found = 1'b1;
      end
    end
`endif
  end

  // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
  always_comb begin
    single_o = (vec_i != '0) && ((vec_i & (vec_i - N'(1))) == '0);
  end

endmodule
`default_nettype wire

// File: rtl/prio_encoder_drain.sv
`default_nettype none
// ============================================================================
// Module      : prio_encoder_drain
// Description : Registered priority encoder with valid/ready on both sides.
//               mode=0 emits the single highest-priority index; mode=1 drains
//               every set bit, one beat per accepted cycle. All-zero vectors
//               produce one beat flagged out_none.
//               Build macro: PRIO_ENCODER_MSB_FIRST_EN selects MSB-first
//               priority (default is LSB-first).
// Revision    : 1.0 - initial release
// ============================================================================
module prio_encoder_drain
  import encoder_pkg::*;
#(
  parameter  int N = DEFAULT_N,
  localparam int W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  input  logic         mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none
);

  state_e       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         mode_q, mode_d;
  logic         zero_q, zero_d;

  logic [W-1:0] w_idx;
  logic         w_single;

  prio_find #(.N(N)) u_prio_find (
    .vec_i    (pending_q),
    .idx_o    (w_idx),
    .single_o (w_single)
  );

  // State and captured-vector registers; reset discards any pending beats.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      mode_q    <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      mode_q    <= mode_d;
      zero_q    <= zero_d;
    end
  end

  // Next-state and handshake outputs; beat fields are forced to 0 outside EMIT.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    mode_d    = mode_q;
    zero_d    = zero_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_idx   = '0;
    out_last  = 1'b0;
    out_none  = 1'b0;

    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pending_d = in_vec;
          mode_d    = mode;
          zero_d    = (in_vec == '0);
          state_d   = EMIT;
        end
      end

      EMIT: begin
        out_valid = 1'b1;
        out_idx   = w_idx;
        out_none  = zero_q;
        out_last  = zero_q | ~mode_q | w_single;
        if (out_ready) begin
          if (out_last) begin
            pending_d = '0;
            state_d   = IDLE;
          end else begin
            // Drain: retire the bit just emitted; the next one surfaces next cycle.
            pending_d[w_idx] = 1'b0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
`default_nettype wire
